// File: rtl/vr_vc_tx_bridge.sv
// vr_vc_tx_bridge: valid/ready slave to valid/credit master transmitter.
// Upstream beats land in a 2-entry skid buffer and are forwarded as
// single-cycle m_valid_o strobes while the transmitter holds credit.
// Optional feature macro: VR_VC_TX_CREDIT_CHECK_EN enables the sticky
// credit_err_o overflow flag and a simulation assertion on credit overflow.
// With the macro undefined, credit_err_o is tied low and an overflowing
// credit return is dropped silently (the counter saturates).
module vr_vc_tx_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int CREDIT_NUM = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_credit_i,
    output logic                  credit_err_o
);

    localparam int              CW         = $clog2(CREDIT_NUM + 1);
    localparam logic [CW-1:0]   CREDIT_MAX = CW'(CREDIT_NUM);

    // Skid buffer storage and bookkeeping
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic [CW-1:0]         credit_cnt;

    // Next-state terms
    logic                  accept;
    logic                  send;
    logic [1:0]            occ_next;
    logic [CW-1:0]         credit_next;

    // Handshake decode, occupancy and credit next-state; all decisions are
    // taken from registered state so m_credit_i never reaches m_valid_o
    // combinationally.
    always_comb begin
        accept      = s_valid_i && s_ready_o;
        send        = (occ != 2'd0) && (credit_cnt != '0);
        occ_next    = occ + {1'b0, accept} - {1'b0, send};
        credit_next = credit_cnt;
        case ({send, m_credit_i})
            2'b10:   credit_next = credit_cnt - CW'(1);
            2'b01:   credit_next = (credit_cnt == CREDIT_MAX) ? credit_cnt
                                                              : credit_cnt + CW'(1);
            default: credit_next = credit_cnt;
        endcase
    end

    // Control state and downstream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
            credit_cnt <= CREDIT_MAX;
            s_ready_o  <= 1'b1;
            m_valid_o  <= 1'b0;
            m_data_o   <= '0;
        end else begin
            occ        <= occ_next;
            credit_cnt <= credit_next;
            s_ready_o  <= (occ_next != 2'd2);
            m_valid_o  <= send;
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (send) begin
                rd_ptr   <= ~rd_ptr;
                m_data_o <= buf_mem[rd_ptr];
            end
        end
    end

    // Payload storage; only the occupancy decides whether an entry is live
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[wr_ptr] <= s_data_i;
        end
    end

`ifdef VR_VC_TX_CREDIT_CHECK_EN
    // A credit returned while already full and not spending one this edge
    logic overflow;
    assign overflow = m_credit_i && !send && (credit_cnt == CREDIT_MAX);

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_err_o <= 1'b0;
        end else if (overflow) begin
            credit_err_o <= 1'b1;
        end
    end

    credit_overflow_a: assert property (@(posedge clk) disable iff (rst) !overflow);
`else
    assign credit_err_o = 1'b0;
`endif

endmodule

// File: doc/vr_vc_tx_bridge.md
Name: vr_vc_tx_bridge

Overview:
- Valid/ready to valid/credit transmitter. Sits directly upstream of the valid/credit receiver and feeds its valid/credit slave port.
- Accepts beats on a valid/ready slave interface into a 2-entry skid buffer.
- Forwards each beat as a single-cycle valid pulse, but only while the transmitter holds credit.
- Credits start at CREDIT_NUM. One credit is consumed per beat sent and one is restored per m_credit_i pulse.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- CREDIT_NUM, 2, initial and maximum credit count. Must equal the receiver buffer depth. Legal range is 1 or more.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_data_i  input  DATA_WIDTH  upstream payload.
- s_valid_i  input  1  upstream beat valid.
- s_ready_o  output  1  bridge can accept a beat. Registered.
- m_data_o  output  DATA_WIDTH  downstream payload. Registered.
- m_valid_o  output  1  downstream beat strobe, one cycle per beat. Registered.
- m_credit_i  input  1  one-cycle pulse returning one credit.
- credit_err_o  output  1  sticky credit-overflow flag (see Optional Feature).

Behaviour:
- Interface timing is fixed: one clock; reset is asynchronous and active-high.
- Reset values:
  - s_ready_o=1, m_valid_o=0, m_data_o=0, credit_err_o=0.
  - Credit counter = CREDIT_NUM. Buffer empty, both pointers 0.
- Credit counter width is $clog2(CREDIT_NUM+1) bits.
- Skid buffer:
  - 2 entries with write/read pointers and an occupancy count of 0..2.
  - Accept condition: s_valid_i && s_ready_o. Data is written at the write pointer on that edge.
  - s_ready_o is the registered "occupancy after this edge < 2". It drops the cycle after the second entry fills.
  - s_valid_i while s_ready_o=0 is ignored; the beat is not lost because the upstream holds it under valid/ready rules.
- Send condition: occupancy != 0 && credit counter != 0. Both are evaluated on registered values only.
  - On send: m_valid_o<=1, m_data_o<=head entry, pop head, credit counter decrements by 1.
  - Otherwise m_valid_o<=0 and m_data_o holds its last value.
- Back-to-back sends are allowed: m_valid_o stays high on consecutive cycles while both credits and data exist.
- Minimum latency is 2 cycles: a beat accepted at edge E is sent at edge E+1 and is visible on m_valid_o after E+1.
- Simultaneous accept and send on the same edge: occupancy is unchanged and s_ready_o stays 1.
- Credit arithmetic per edge: cnt_next = cnt - send + m_credit_i.
  - Send and return on the same edge leave the count unchanged.
  - A credit returned at edge E can be used for a send at edge E+1 at the earliest. No combinational path from m_credit_i to m_valid_o.
- Boundary at credit count 0: no send. The buffer fills and s_ready_o drops after 2 accepts.
- Boundary at credit count CREDIT_NUM with m_credit_i=1 and no send:
  - Overflow. The counter saturates at CREDIT_NUM.
  - Error handling is described under Optional Feature.
- Pointer wrap: the 1-bit pointers wrap modulo 2.
- Reset asserted mid-operation:
  - Immediately clears the buffer, m_valid_o, and credit_err_o, and restores CREDIT_NUM credits.
  - Beats in flight are discarded. The receiver must be reset together with this block.

Optional Feature:
- Macro: VR_VC_TX_CREDIT_CHECK_EN.
- Defined:
  - An overflow sets credit_err_o=1.
  - The flag stays set until rst.
  - An assertion fires in simulation.
- Undefined:
  - credit_err_o is tied to 0.
  - The counter still saturates silently.
  - No checking logic is generated.

Test Plan:
- Reset then single beat: s_data_i=0xA5 held 1 cycle -> m_valid_o high exactly 1 cycle, 2 cycles after the accept, m_data_o=0xA5; credit count 2->1.
- Credit exhaustion with CREDIT_NUM=2 and no m_credit_i: stream 0x01..0x05 -> only 0x01 and 0x02 are sent; 0x03 and 0x04 are buffered; s_ready_o=0 while 0x05 is held; credit count=0.
- Credit return from the previous state: pulse m_credit_i once -> exactly one beat (0x03) is sent 1 cycle after the pulse edge; s_ready_o rises and 0x05 is accepted.
- Simultaneous send and return: steady stream with m_credit_i pulsed every cycle -> m_valid_o high continuously, credit count constant, data order preserved.
- Overflow, macro defined: with credit count=2 and idle, pulse m_credit_i -> credit_err_o=1, sticky; count stays 2. Macro undefined: credit_err_o stays 0.
- Reset mid-stream: assert rst with 2 beats buffered and credit count 0 -> immediately m_valid_o=0, s_ready_o=1, credit count=2, credit_err_o=0; the next beat passes normally.
